stopwatch_time_counter: RTL and testbench
=========================================

Name: stopwatch_time_counter

Overview:
Timekeeping datapath driven by the stopwatch control FSM's count_en / clear_counters outputs, i.e. the consumer end of that control interface.
- Prescales the system clock to a 1 s tick.
- Maintains an MM:SS elapsed time as four BCD digits for the display driver.
- Emits per-second and wrap pulses for downstream status logic.

Parameters:
- TICK_DIV, 100000000: clk cycles per counted second; must be >= 2; bench uses 4.
- PRESC_W, $clog2(TICK_DIV): prescaler width, derived, not overridden.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- count_en  in  1  level; advance time while high.
- clear_counters  in  1  level; synchronous clear of all time state.
- sec_ones  out  4  BCD seconds units, 0-9.
- sec_tens  out  4  BCD seconds tens, 0-5.
- min_ones  out  4  BCD minutes units, 0-9.
- min_tens  out  4  BCD minutes tens, 0-9.
- sec_tick  out  1  one-cycle pulse on the cycle the seconds value increments.
- wrap  out  1  one-cycle pulse on the 99:59 -> 00:00 transition.

Behaviour:
- Reset: on rst high at a clk edge, prescaler, all four digits, sec_tick and wrap are cleared to 0. All outputs are registered.
- Clear: clear_counters has the same effect as rst on the next edge. Priority order: rst > clear_counters > count_en. When clear and count_en are high together, clear wins: no increment and no pulse that cycle.
- Prescaler: counts 0..TICK_DIV-1 only on cycles with count_en=1. It holds its value when count_en=0, so pause/resume preserves the sub-second fraction.
  - An enabled cycle with prescaler==TICK_DIV-1 is a "tick cycle". On that edge the prescaler goes to 0 and the time increments by 1 s.
  - Latency: the first tick occurs on the TICK_DIV-th enabled edge after a clear.
- Digit carry chain, all updated in the same edge (no ripple latency):
  - sec_ones 9 -> 0 carries into sec_tens.
  - sec_tens 5 -> 0 carries into min_ones.
  - min_ones 9 -> 0 carries into min_tens.
  - min_tens 9 -> 0 at 99:59 wraps to 00:00.
- sec_tick: registered, high for exactly the cycle following each tick cycle (aligned with the new digit values), otherwise 0.
- wrap: registered, high together with sec_tick on the cycle the display first shows 00:00 after 99:59.
- count_en low: digits and prescaler hold. sec_tick/wrap return to 0 on the next edge, even if they were high.
- rst or clear asserted mid-second: discards the partial prescale count. There is no carry-over.
- Out-of-range digit values are unreachable. The implementation still forces any digit above its max to 0 on increment.
- No combinational path from inputs to outputs.

Decomposition:
- stopwatch_pkg holds:
  - BCD_DIGIT_MAX=9, SEC_TENS_MAX=5, DIGIT_W=4.
  - Shared status encodings ST_IDLE=2'b00, ST_RUNNING=2'b01, ST_PAUSED=2'b10, used by the control FSM and top-level.
- One sub-module: bcd_digit, instantiated four times.
  - Parameter MAX; inputs clk, rst, clr, inc.
  - Outputs digit[3:0] and a combinational carry = inc && digit==MAX.
- The top module contains the prescaler, the enable/clear priority logic and the pulse registers.

Test Plan (TICK_DIV=4):
1. Reset: hold rst 2 cycles with count_en=1 -> all digits 0, sec_tick=0, wrap=0. After release, the first sec_tick comes on the cycle after the 4th enabled edge, with sec_ones=1.
2. Pause fraction: count_en high 2 cycles, low 10 cycles, high 2 cycles -> sec_ones goes 0->1 exactly after the 4th enabled edge, with no change during the pause.
3. Carry: run 240 enabled cycles (60 s) -> 01:00. Tenth-second check: after 40 cycles the display reads 00:10.
4. Wrap: run 6000 s (24000 enabled cycles) -> 99:59 -> 00:00. wrap and sec_tick are both high for 1 cycle, and wrap is 0 on every other cycle.
5. Clear priority: at 00:07 with prescaler=3, assert clear_counters and count_en together for 1 cycle -> 00:00, no sec_tick. The next tick needs 4 further enabled cycles.
6. Reset mid-operation: rst pulsed 1 cycle at 12:34 during a tick cycle -> 00:00, sec_tick=0 and wrap=0 the following cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants, status encodings and digit helpers for the stopwatch blocks.
// Imported by the control FSM, the time counter and its digit cells.
package stopwatch_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;

    localparam logic [DIGIT_W-1:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX  = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10
    } sw_status_e;

    // Next value of a counting digit; anything at or above max returns to zero,
    // which also recovers from an out-of-range value.
    function automatic logic [DIGIT_W-1:0] bcd_next(
        input logic [DIGIT_W-1:0] d,
        input logic [DIGIT_W-1:0] max
    );
        logic [DIGIT_W-1:0] res;
        if (d >= max) begin
            res = '0;
        end else begin
            res = d + 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/stopwatch_time_counter_bcd_digit.sv
// One decimal digit of the elapsed-time display: counts 0..MAX on inc, with a
// same-cycle carry so the whole chain advances on a single edge.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = BCD_DIGIT_MAX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry
);

    logic [DIGIT_W-1:0] digit_reg;
    logic [DIGIT_W-1:0] digit_next;

    always_comb begin
        digit_next = digit_reg;
        if (inc) begin
            digit_next = bcd_next(digit_reg, MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            digit_reg <= '0;
        end else begin
            digit_reg <= digit_next;
        end
    end

    assign digit = digit_reg;
    assign carry = inc && (digit_reg == MAX);

endmodule

// File: rtl/stopwatch_time_counter.sv
// Elapsed-time datapath: prescales clk to a 1 s tick while count_en is high and
// keeps MM:SS as four BCD digits, with per-second and 99:59 wrap pulses.
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int PRESC_W  = $clog2(TICK_DIV)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               count_en,
    input  logic               clear_counters,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] min_tens,
    output logic               sec_tick,
    output logic               wrap
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_reg;
    logic [PRESC_W-1:0] presc_next;
    logic               sec_tick_reg;
    logic               wrap_reg;
    logic               tick;

    logic [NUM_DIGITS-1:0]              inc_chain;
    logic [NUM_DIGITS-1:0]              carry;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digit_val;

    // Clear outranks count_en: no tick and no prescaler advance on a clear cycle.
    always_comb begin
        tick       = 1'b0;
        presc_next = presc_reg;
        if (clear_counters) begin
            presc_next = '0;
        end else if (count_en) begin
            if (presc_reg == PRESC_LAST) begin
                tick       = 1'b1;
                presc_next = '0;
            end else begin
                presc_next = presc_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg    <= '0;
            sec_tick_reg <= 1'b0;
            wrap_reg     <= 1'b0;
        end else begin
            presc_reg    <= presc_next;
            sec_tick_reg <= tick;
            wrap_reg     <= carry[NUM_DIGITS-1];
        end
    end

    // Digit order: 0 = sec_ones, 1 = sec_tens, 2 = min_ones, 3 = min_tens.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_first
                assign inc_chain[gi] = tick;
            end else begin : g_rest
                assign inc_chain[gi] = carry[gi-1];
            end

            bcd_digit #(
                .MAX((gi == 1) ? SEC_TENS_MAX : BCD_DIGIT_MAX)
            ) u_digit (
                .clk   (clk),
                .rst   (rst),
                .clr   (clear_counters),
                .inc   (inc_chain[gi]),
                .digit (digit_val[gi]),
                .carry (carry[gi])
            );
        end
    endgenerate

    assign sec_ones = digit_val[0];
    assign sec_tens = digit_val[1];
    assign min_ones = digit_val[2];
    assign min_tens = digit_val[3];
    assign sec_tick = sec_tick_reg;
    assign wrap     = wrap_reg;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Self-checking bench for stopwatch_time_counter with TICK_DIV=4: a vector table,
// directed corner sequences and a randomized run against an elapsed-seconds model.
module tb_stopwatch_time_counter;

    localparam int TICK_DIV = 4;
    localparam int WRAP_SECS = 6000;

    logic       clk;
    logic       rst;
    logic       count_en;
    logic       clear_counters;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       sec_tick;
    logic       wrap;

    stopwatch_time_counter #(
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .count_en       (count_en),
        .clear_counters (clear_counters),
        .sec_ones       (sec_ones),
        .sec_tens       (sec_tens),
        .min_ones       (min_ones),
        .min_tens       (min_tens),
        .sec_tick       (sec_tick),
        .wrap           (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int wrap_count = 0;

    // Reference model: elapsed whole seconds plus enabled edges into the current second.
    int   ref_secs = 0;
    int   ref_frac = 0;
    logic exp_tick = 1'b0;
    logic exp_wrap = 1'b0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       clr;
        logic [3:0] so;
        logic [3:0] st;
        logic [3:0] mo;
        logic [3:0] mt;
        logic       tick;
        logic       wrp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] model_digits(input int secs);
        int mm;
        int ss;
        mm = secs / 60;
        ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [15:0] dut_digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    function automatic string fmt_time(input logic [15:0] d);
        return $sformatf("%0d%0d:%0d%0d", d[15:12], d[11:8], d[7:4], d[3:0]);
    endfunction

    task automatic check_eq(input string name, input logic [17:0] got, input logic [17:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got time %s tick=%0b wrap=%0b, required time %s tick=%0b wrap=%0b",
                     name, fmt_time(got[17:2]), got[1], got[0],
                     fmt_time(req[17:2]), req[1], req[0]);
        end
    endtask

    // One clock: drive inputs, advance, update the model, compare every output.
    task automatic step(input logic r, input logic e, input logic c);
        rst            = r;
        count_en       = e;
        clear_counters = c;
        @(posedge clk);
        #1;
        if (r || c) begin
            ref_secs = 0;
            ref_frac = 0;
            exp_tick = 1'b0;
            exp_wrap = 1'b0;
        end else if (e) begin
            ref_frac++;
            if (ref_frac == TICK_DIV) begin
                ref_frac = 0;
                ref_secs = (ref_secs + 1) % WRAP_SECS;
                exp_tick = 1'b1;
                exp_wrap = (ref_secs == 0);
            end else begin
                exp_tick = 1'b0;
                exp_wrap = 1'b0;
            end
        end else begin
            exp_tick = 1'b0;
            exp_wrap = 1'b0;
        end
        if (wrap === 1'b1) wrap_count++;
        check_eq("model", {dut_digits(), sec_tick, wrap},
                 {model_digits(ref_secs), exp_tick, exp_wrap});
    endtask

    task automatic run_en(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic add_vec(input logic r, input logic e, input logic c,
                           input int so, input int tick, input int reps);
        vec_t v;
        v.rst = r; v.en = e; v.clr = c;
        v.so = 4'(so); v.st = 4'd0; v.mo = 4'd0; v.mt = 4'd0;
        v.tick = tick[0]; v.wrp = 1'b0;
        for (int i = 0; i < reps; i++) vecs.push_back(v);
    endtask

    task automatic checkpoint(input string name, input logic [15:0] req_t,
                              input logic req_tick, input logic req_wrap);
        check_eq(name, {dut_digits(), sec_tick, wrap}, {req_t, req_tick, req_wrap});
        $display("[%0t] %s: time %s tick=%0b wrap=%0b", $time, name,
                 fmt_time(dut_digits()), sec_tick, wrap);
    endtask

    initial begin
        logic r;
        logic c;
        logic e;
        rst = 1'b1;
        count_en = 1'b1;
        clear_counters = 1'b0;

        // Reset, first-tick latency, pause preserving fraction, drop of pulse, clear.
        add_vec(1, 1, 0, 0, 0, 2);
        add_vec(0, 1, 0, 0, 0, 3);
        add_vec(0, 1, 0, 1, 1, 1);
        add_vec(0, 1, 0, 1, 0, 2);
        add_vec(0, 0, 0, 1, 0, 10);
        add_vec(0, 1, 0, 1, 0, 1);
        add_vec(0, 1, 0, 2, 1, 1);
        add_vec(0, 0, 0, 2, 0, 1);
        add_vec(0, 1, 1, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].clr);
            check_eq($sformatf("vec%0d", i), {dut_digits(), sec_tick, wrap},
                     {vecs[i].mt, vecs[i].mo, vecs[i].st, vecs[i].so, vecs[i].tick, vecs[i].wrp});
            $display("[%0t] vec%0d rst=%0b en=%0b clr=%0b -> time %s tick=%0b wrap=%0b",
                     $time, i, vecs[i].rst, vecs[i].en, vecs[i].clr,
                     fmt_time(dut_digits()), sec_tick, wrap);
        end

        // Seconds-tens and minute carries.
        step(1'b0, 1'b0, 1'b1);
        run_en(40);
        checkpoint("ten_seconds", 16'h0010, 1'b1, 1'b0);
        run_en(200);
        checkpoint("one_minute", 16'h0100, 1'b1, 1'b0);

        // Full wrap 99:59 -> 00:00.
        step(1'b0, 1'b0, 1'b1);
        wrap_count = 0;
        run_en(5999 * TICK_DIV);
        checkpoint("at_9959", 16'h9959, 1'b1, 1'b0);
        run_en(TICK_DIV - 1);
        checkpoint("pre_wrap_hold", 16'h9959, 1'b0, 1'b0);
        run_en(1);
        checkpoint("wrap_edge", 16'h0000, 1'b1, 1'b1);
        run_en(1);
        checkpoint("post_wrap", 16'h0000, 1'b0, 1'b0);
        n_cmp++;
        if (wrap_count != 1) begin
            n_fail++;
            $display("FAIL wrap_pulse_count: got %0d pulses, required 1", wrap_count);
        end

        // Clear together with count_en on a tick cycle.
        step(1'b0, 1'b0, 1'b1);
        run_en(7 * TICK_DIV + 3);
        checkpoint("at_0007_p3", 16'h0007, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        checkpoint("clear_wins", 16'h0000, 1'b0, 1'b0);
        run_en(TICK_DIV - 1);
        checkpoint("clear_no_carry", 16'h0000, 1'b0, 1'b0);
        run_en(1);
        checkpoint("clear_next_tick", 16'h0001, 1'b1, 1'b0);

        // Reset on a tick cycle at 12:34.
        step(1'b0, 1'b0, 1'b1);
        run_en(754 * TICK_DIV + 3);
        checkpoint("at_1234_p3", 16'h1234, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        checkpoint("reset_mid", 16'h0000, 1'b0, 1'b0);
        run_en(TICK_DIV);
        checkpoint("reset_next_tick", 16'h0001, 1'b1, 1'b0);

        // Randomized control levels against the model.
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 99) < 2);
            e = ($urandom_range(0, 9) < 7);
            step(r, e, c);
        end
        $display("[%0t] random run done: time %s", $time, fmt_time(dut_digits()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
